apb_master: RTL

Single-outstanding APB requester that turns a simple valid/ready command port into APB IDLE/SETUP/ACCESS transfers and returns one response per command. It is the initiator side of the APB bus used by the 8-bit timer's register block (TDR/TCR/TSR), used by test harnesses and future on-chip sequencers to program and poll the timer. It adds wait-state handling and a bounded-wait timeout so a non-responding completer cannot hang the requester.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_master_if.sv | 35 +++
 rtl/apb_timeout_counter.sv | 26 ++
 rtl/apb_master.sv | 109 ++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding common to requester and completer,
// plus the timer register map.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [7:0] TDR_ADDR  = 8'h00;
    localparam logic [7:0] TCR_ADDR  = 8'h01;
    localparam logic [7:0] TSR_ADDR  = 8'h02;
    localparam logic [7:0] TCR_WMASK = 8'hB3;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port and APB bus of the requester, bundled together.
interface apb_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-cycle counter; expired flags the cycle whose edge
// would bring the count up to TIMEOUT.
module apb_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned    CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
        end else if (enable && count_q != LIMIT) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = enable && (count_q == LIMIT - CW'(1));
endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS transfer,
// one response out, with a bounded wait on pready.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    apb_master_if.master bus
);
    apb_state_e state_q, state_d;

    logic              accept, done, abort, expired;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q, rsp_slverr_q, rsp_timeout_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        done          = 1'b0;
        abort         = 1'b0;
        bus.psel      = 1'b0;
        bus.penable   = 1'b0;
        bus.cmd_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                bus.psel = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                // pready wins over a timeout expiring in the same cycle
                if (bus.pready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= done | abort;
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
            end
            if (done) begin
                rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                rsp_slverr_q  <= bus.pslverr;
                rsp_timeout_q <= 1'b0;
            end else if (abort) begin
                rsp_rdata_q   <= '0;
                rsp_slverr_q  <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    apb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == SETUP),
        .enable (state_q == ACCESS),
        .expired(expired)
    );

    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
